// File: rtl/sample_ctrl_pkg.sv
// Shared types and widths for the sample-cycle sequencer.
//   sc_state_e : sequencer states
//   ERR_CNT_W  : width of the saturating error-sample counter
//   RESULT_W   : width of the analysis result
//   ERR_CODE_W : width of the ADC error code
package sample_ctrl_pkg;

    localparam int unsigned ERR_CNT_W  = 8;
    localparam int unsigned RESULT_W   = 16;
    localparam int unsigned ERR_CODE_W = 2;

    typedef enum logic [2:0] {
        SC_IDLE   = 3'd0,
        SC_SAMPLE = 3'd1,
        SC_CLOSE  = 3'd2,
        SC_WAIT   = 3'd3,
        SC_HOLD   = 3'd4
    } sc_state_e;

    // Increment that sticks at all-ones.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Conversion-request divider: emits a one-clock pulse every CLK_DIV clocks.
// The pulse is registered and aligned so that a clear produces a pulse in
// the very next clock, followed by one pulse every CLK_DIV clocks while
// i_en stays high.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clear      : restart the divider (pulse in the following clock)
//   i_en         : keep counting (next clock remains in the pulsing phase)
//   o_pulse      : registered request pulse
module sample_strobe_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_pulse
);

    localparam int unsigned          CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    // r_cnt is the divider phase of the current clock; the pulse register
    // is loaded with the phase-0 decode of the next clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
        end else if (i_en) begin
            r_cnt   <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_pulse <= w_wrap;
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/sample_cycle_controller.sv
// Sequencer for the ADC sample-analysis path: paces ADC requests, counts
// good samples into windows, closes each window with end_cycle, waits for
// the analysis result and offers it on a valid/ready handshake.
//   clk, reset_n               : clock, asynchronous active-low reset
//   enable                     : run windows back-to-back while high
//   adc_sample_req             : one-clock conversion request
//   ast_sink_valid/_error      : ADC sample strobe and error code
//   end_cycle                  : window-close level to the analysis block
//   source_valid/_data         : analysis result strobe and data
//   result_data/_valid/_ready  : result handshake to the consumer
//   busy, timeout, err_count   : status (timeout sticky until reset)
module sample_cycle_controller
    import sample_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV           = 50,
    parameter int unsigned SAMPLES_PER_CYCLE = 256,
    parameter int unsigned RESULT_TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  adc_sample_req,
    input  logic                  ast_sink_valid,
    input  logic [ERR_CODE_W-1:0] ast_sink_error,
    output logic                  end_cycle,
    input  logic                  source_valid,
    input  logic [RESULT_W-1:0]   source_data,
    output logic [RESULT_W-1:0]   result_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic                  timeout,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int unsigned          SMP_W    = $clog2(SAMPLES_PER_CYCLE + 1);
    localparam int unsigned          TO_W     = $clog2(RESULT_TIMEOUT + 1);
    localparam logic [SMP_W-1:0]     SMP_LAST = SMP_W'(SAMPLES_PER_CYCLE - 1);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(RESULT_TIMEOUT - 1);

    sc_state_e             r_state;
    sc_state_e             w_next;

    logic [SMP_W-1:0]      r_smp_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic [RESULT_W-1:0]   r_result_data;
    logic                  r_timeout;
    logic                  r_end_cycle;
    logic                  r_result_valid;
    logic                  r_busy;

    logic                  w_accept;
    logic                  w_reject;
    logic                  w_last_smp;
    logic                  w_to_expire;
    logic                  w_handshake;
    logic                  w_enter_sample;
    logic                  w_stay_sample;
    logic                  w_end_cycle_nxt;
    logic                  w_result_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_req;

    assign w_accept    = (r_state == SC_SAMPLE) && ast_sink_valid && (ast_sink_error == '0);
    assign w_reject    = (r_state == SC_SAMPLE) && ast_sink_valid && (ast_sink_error != '0);
    assign w_last_smp  = w_accept && (r_smp_cnt == SMP_LAST);
    // A result arriving on the last allowed clock takes priority over expiry.
    assign w_to_expire = (r_state == SC_WAIT) && !source_valid && (r_to_cnt == TO_LAST);
    assign w_handshake = (r_state == SC_HOLD) && r_result_valid && result_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SC_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            SC_IDLE:   if (enable) w_next = SC_SAMPLE;
            SC_SAMPLE: if (w_last_smp) w_next = SC_CLOSE;
            SC_CLOSE:  w_next = SC_WAIT;
            SC_WAIT: begin
                if (source_valid) begin
                    w_next = SC_HOLD;
                end else if (w_to_expire) begin
                    w_next = SC_IDLE;
                end
            end
            SC_HOLD:   if (w_handshake) w_next = enable ? SC_SAMPLE : SC_IDLE;
            default:   w_next = SC_IDLE;
        endcase
    end

    // Output decode of the next state, registered below so outputs track state.
    always_comb begin
        w_enter_sample     = 1'b0;
        w_stay_sample      = 1'b0;
        w_end_cycle_nxt    = 1'b0;
        w_result_valid_nxt = 1'b0;
        w_busy_nxt         = 1'b0;
        w_enter_sample     = (w_next == SC_SAMPLE) && (r_state != SC_SAMPLE);
        w_stay_sample      = (w_next == SC_SAMPLE) && (r_state == SC_SAMPLE);
        w_end_cycle_nxt    = (w_next == SC_CLOSE) || (w_next == SC_WAIT);
        w_result_valid_nxt = (w_next == SC_HOLD);
        w_busy_nxt         = (w_next != SC_IDLE);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_end_cycle    <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_end_cycle    <= w_end_cycle_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    // Window counters, error counter, timeout flag and result latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_smp_cnt     <= '0;
            r_to_cnt      <= '0;
            r_err_cnt     <= '0;
            r_result_data <= '0;
            r_timeout     <= 1'b0;
        end else begin
            if (w_enter_sample) begin
                r_smp_cnt <= '0;
            end else if (w_accept) begin
                r_smp_cnt <= r_smp_cnt + SMP_W'(1);
            end

            // WAIT is only ever entered from CLOSE.
            if (r_state == SC_CLOSE) begin
                r_to_cnt <= '0;
            end else if (r_state == SC_WAIT) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_reject) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end

            if ((r_state == SC_WAIT) && source_valid) begin
                r_result_data <= source_data;
            end

            if (w_to_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    sample_strobe_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_enter_sample),
        .i_en    (w_stay_sample),
        .o_pulse (w_req)
    );

    assign adc_sample_req = w_req;
    assign end_cycle      = r_end_cycle;
    assign result_valid   = r_result_valid;
    assign result_data    = r_result_data;
    assign busy           = r_busy;
    assign timeout        = r_timeout;
    assign err_count      = r_err_cnt;

endmodule

// File: tb/tb_sample_cycle_controller.sv
// Self-checking bench for sample_cycle_controller (CLK_DIV=4, 8 samples per
// window, result timeout 16 clocks).
module tb_sample_cycle_controller;

    localparam int unsigned P_DIV = 4;
    localparam int unsigned P_SPC = 8;
    localparam int unsigned P_TO  = 16;

    localparam int PH_IDLE   = 0;
    localparam int PH_SAMPLE = 1;
    localparam int PH_CLOSE  = 2;
    localparam int PH_WAIT   = 3;
    localparam int PH_HOLD   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        result_ready = 1'b0;
    logic        ast_sink_valid = 1'b0;
    logic [1:0]  ast_sink_error = 2'b00;
    logic        source_valid = 1'b0;
    logic [15:0] source_data = 16'h0000;
    logic        adc_sample_req;
    logic        end_cycle;
    logic [15:0] result_data;
    logic        result_valid;
    logic        busy;
    logic        timeout;
    logic [7:0]  err_count;

    sample_cycle_controller #(
        .CLK_DIV           (P_DIV),
        .SAMPLES_PER_CYCLE (P_SPC),
        .RESULT_TIMEOUT    (P_TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .adc_sample_req (adc_sample_req),
        .ast_sink_valid (ast_sink_valid),
        .ast_sink_error (ast_sink_error),
        .end_cycle      (end_cycle),
        .source_valid   (source_valid),
        .source_data    (source_data),
        .result_data    (result_data),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .busy           (busy),
        .timeout        (timeout),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int          phase;
        int          age;     // clocks spent in the current phase
        int          good;    // accepted samples this window
        int          err;     // discarded samples, saturating
        logic [15:0] result;
        bit          tmo;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.phase = PH_IDLE; r.age = 0; r.good = 0; r.err = 0;
        r.result = 16'h0000; r.tmo = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input logic en, input logic v,
                                      input logic [1:0] e, input logic sv,
                                      input logic [15:0] sd, input logic rdy);
        mdl_t n = s;
        case (s.phase)
            PH_IDLE: if (en) begin n.phase = PH_SAMPLE; n.age = 0; n.good = 0; end
            PH_SAMPLE: begin
                if (v && e == 2'b00) n.good = s.good + 1;
                if (v && e != 2'b00) n.err = (s.err < 255) ? s.err + 1 : 255;
                if (n.good == int'(P_SPC)) n.phase = PH_CLOSE;
                else n.age = s.age + 1;
            end
            PH_CLOSE: begin n.phase = PH_WAIT; n.age = 0; end
            PH_WAIT: begin
                if (sv) begin
                    n.result = sd; n.phase = PH_HOLD;
                end else if (s.age == int'(P_TO) - 1) begin
                    n.tmo = 1'b1; n.phase = PH_IDLE;
                end else begin
                    n.age = s.age + 1;
                end
            end
            PH_HOLD: if (rdy) begin
                if (en) begin n.phase = PH_SAMPLE; n.age = 0; n.good = 0; end
                else n.phase = PH_IDLE;
            end
            default: n.phase = PH_IDLE;
        endcase
        return n;
    endfunction

    initial begin
        m = mdl_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m = mdl_reset();
            else m = mdl_step(m, enable, ast_sink_valid, ast_sink_error,
                              source_valid, source_data, result_ready);
        end
    end

    // Per-cycle comparison of every output against the model.
    bit chk_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_req",   32'(adc_sample_req), 32'((m.phase == PH_SAMPLE) && (m.age % int'(P_DIV) == 0)));
                check("m_end",   32'(end_cycle),      32'((m.phase == PH_CLOSE) || (m.phase == PH_WAIT)));
                check("m_rv",    32'(result_valid),   32'(m.phase == PH_HOLD));
                check("m_busy",  32'(busy),           32'(m.phase != PH_IDLE));
                check("m_tmo",   32'(timeout),        32'(m.tmo));
                check("m_err",   32'(err_count),      32'(m.err));
                check("m_rdata", 32'(result_data),    32'(m.result));
            end
        end
    end

    // ---------------- environment: ADC and analysis responders ----------------
    int          env_mode = 0;      // 0 quiet, 1 responders, 2 random, 3 error flood
    logic [15:0] cfg_err_mask = '0;
    logic [15:0] cfg_data = '0;
    int          cfg_ana_delay = 1;
    bit          cfg_ana_on = 1'b0;
    int          mon_reqs = 0;
    int          mon_rises = 0;

    initial begin
        logic [2:0] req_pipe;
        int         resp_idx;
        bit         ana_pend;
        int         ana_cnt;
        logic       ec_prev;
        req_pipe = '0; resp_idx = 0; ana_pend = 1'b0; ana_cnt = 0; ec_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (adc_sample_req) mon_reqs++;
            if (end_cycle && !ec_prev) mon_rises++;
            ast_sink_valid = 1'b0;
            ast_sink_error = 2'($urandom);
            source_valid   = 1'b0;
            source_data    = 16'($urandom);
            req_pipe = {req_pipe[1:0], adc_sample_req};
            case (env_mode)
                1: if (req_pipe[2]) begin
                    ast_sink_valid = 1'b1;
                    ast_sink_error = (resp_idx < 16 && cfg_err_mask[4'(resp_idx)]) ? 2'b01 : 2'b00;
                    resp_idx++;
                end
                2: begin
                    ast_sink_valid = ($urandom_range(0, 1) == 1);
                    if (ast_sink_valid)
                        ast_sink_error = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    source_valid = ($urandom_range(0, 7) == 0);
                end
                3: begin
                    ast_sink_valid = 1'b1;
                    ast_sink_error = 2'b10;
                end
                default: ;
            endcase
            if (ana_pend) begin
                ana_cnt++;
                if (ana_cnt == cfg_ana_delay) begin
                    source_valid = 1'b1;
                    source_data  = cfg_data;
                    ana_pend     = 1'b0;
                end
            end
            if (end_cycle && !ec_prev && cfg_ana_on) begin
                ana_pend = 1'b1;
                ana_cnt  = 0;
            end
            ec_prev = end_cycle;
            if (!reset_n) begin
                req_pipe = '0; resp_idx = 0; ana_pend = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- table-driven windows ----------------
    typedef struct {
        logic [15:0] err_mask;     // which ADC responses carry an error code
        logic [15:0] data;         // analysis result value
        int          ana_delay;    // clocks from end_cycle rise to source_valid
        int          ready_delay;  // clocks result_ready is held low in HOLD
        int          exp_reqs;
        int          exp_err;
        logic        exp_rv;
        logic        exp_tmo;
        logic [15:0] exp_data;
    } vec_t;

    task automatic run_vector(input vec_t v, input int idx);
        int q0, e0;
        enable = 1'b0; result_ready = 1'b0;
        env_mode = 1; cfg_err_mask = v.err_mask; cfg_data = v.data;
        cfg_ana_delay = v.ana_delay; cfg_ana_on = 1'b1;
        do_reset();
        q0 = mon_reqs; e0 = mon_rises;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 400 && !result_valid && !timeout; i++) @(negedge clk);
        check($sformatf("v%0d_rv", idx),  32'(result_valid), 32'(v.exp_rv));
        check($sformatf("v%0d_tmo", idx), 32'(timeout),      32'(v.exp_tmo));
        if (result_valid) begin
            for (int i = 0; i < v.ready_delay; i++) begin
                check($sformatf("v%0d_hold_data", idx), 32'(result_data), 32'(v.data));
                @(negedge clk);
            end
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_reqs", idx),  32'(mon_reqs - q0),  32'(v.exp_reqs));
        check($sformatf("v%0d_rises", idx), 32'(mon_rises - e0), 32'(1));
        check($sformatf("v%0d_err", idx),   32'(err_count),      32'(v.exp_err));
        check($sformatf("v%0d_data", idx),  32'(result_data),    32'(v.exp_data));
        check($sformatf("v%0d_idle", idx),  32'(busy),           32'(0));
        check($sformatf("v%0d_rv_end", idx), 32'(result_valid),  32'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[5];
        int   r0;
        vecs[0] = '{16'h0000, 16'hBEEF,  5, 3,  8, 0, 1'b1, 1'b0, 16'hBEEF}; // nominal
        vecs[1] = '{16'h0092, 16'h1234,  2, 0, 11, 3, 1'b1, 1'b0, 16'h1234}; // 3 of 11 bad
        vecs[2] = '{16'h00FF, 16'hA5A5,  1, 1, 16, 8, 1'b1, 1'b0, 16'hA5A5}; // 8 bad first
        vecs[3] = '{16'h0000, 16'h0F0F, 16, 0,  8, 0, 1'b1, 1'b0, 16'h0F0F}; // result on last WAIT clock
        vecs[4] = '{16'h0000, 16'h7777, 17, 0,  8, 0, 1'b0, 1'b1, 16'h0000}; // result one clock late

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Reset values and 100 idle clocks with enable low.
        check("rst_req",   32'(adc_sample_req), 32'(0));
        check("rst_end",   32'(end_cycle),      32'(0));
        check("rst_rv",    32'(result_valid),   32'(0));
        check("rst_busy",  32'(busy),           32'(0));
        check("rst_tmo",   32'(timeout),        32'(0));
        check("rst_data",  32'(result_data),    32'(16'h0000));
        check("rst_err",   32'(err_count),      32'(8'h00));
        r0 = mon_reqs;
        repeat (100) @(negedge clk);
        check("idle_reqs", 32'(mon_reqs - r0),  32'(0));
        check("idle_busy", 32'(busy),           32'(0));

        for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

        // Error flood saturates err_count while the window stays open.
        env_mode = 3; cfg_ana_on = 1'b0;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        check("sat_err",  32'(err_count), 32'(255));
        check("sat_busy", 32'(busy),      32'(1));

        // Timeout: no result, exactly 16 WAIT clocks then IDLE.
        env_mode = 1; cfg_err_mask = '0; cfg_ana_on = 1'b0;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 200 && !end_cycle; i++) @(negedge clk);
        check("to_close", 32'(end_cycle), 32'(1));
        repeat (16) @(negedge clk);
        check("to_last_wait_end", 32'(end_cycle), 32'(1));
        check("to_last_wait_tmo", 32'(timeout),   32'(0));
        @(negedge clk);
        check("to_tmo",  32'(timeout),      32'(1));
        check("to_end",  32'(end_cycle),    32'(0));
        check("to_busy", 32'(busy),         32'(0));
        check("to_rv",   32'(result_valid), 32'(0));

        // Backpressure then back-to-back restart.
        env_mode = 1; cfg_data = 16'hC3C3; cfg_ana_delay = 5; cfg_ana_on = 1'b1;
        do_reset();
        enable = 1'b1; result_ready = 1'b0;
        for (int i = 0; i < 200 && !result_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_rv",   32'(result_valid), 32'(1));
            check("bp_data", 32'(result_data),  32'(16'hC3C3));
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        check("b2b_req",  32'(adc_sample_req), 32'(1));
        check("b2b_rv",   32'(result_valid),   32'(0));
        check("b2b_busy", 32'(busy),           32'(1));
        enable = 1'b0;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("b2b_idle", 32'(busy), 32'(0));
        result_ready = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        env_mode = 1; cfg_ana_on = 1'b0;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 200 && !end_cycle; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mw_end_before", 32'(end_cycle), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("mw_end_async",  32'(end_cycle), 32'(0));
        check("mw_busy_async", 32'(busy),      32'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mw_idle", 32'(busy), 32'(0));

        // Randomized traffic against the model.
        env_mode = 2; cfg_ana_on = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            enable       = ($urandom_range(0, 7) != 0);
            result_ready = ($urandom_range(0, 2) != 0);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_cycle_controller.md
# sample_cycle_controller

Sequencer for the ADC sample-analysis path. It paces conversion requests to the ADC, counts accepted samples into fixed-size measurement windows, and raises `end_cycle` to close each window. It then waits for the analysis block's 16-bit result and presents that result to a downstream consumer over a valid/ready handshake. It sits between the ADC streaming interface and the analysis block, driving the analysis block's `end_cycle` input and consuming its `source_valid`/`source_data` output.

## Interface
- `CLK_DIV`, 50: clocks between consecutive `adc_sample_req` pulses; legal range ≥2.
- `SAMPLES_PER_CYCLE`, 256: accepted samples per window; legal range ≥1.
- `RESULT_TIMEOUT`, 1024: clocks allowed in WAIT_RESULT before abort; legal range ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; high runs windows back-to-back, low stops after the current window completes.
- `adc_sample_req`  out  1  one-clock conversion request pulse to the ADC.
- `ast_sink_valid`  in  1  ADC sample strobe; monitored only.
- `ast_sink_error`  in  2  ADC error code; qualified by `ast_sink_valid`.
- `end_cycle`  out  1  level to the analysis block; its rising edge closes a window.
- `source_valid`  in  1  analysis result strobe.
- `source_data`  in  16  analysis result.
- `result_data`  out  16  latched result.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.
- `timeout`  out  1  sticky; set on result timeout, cleared only by reset.
- `err_count`  out  8  saturating count of samples discarded for error.

## Operation
- States: IDLE, SAMPLE, CLOSE, WAIT_RESULT, HOLD.
- IDLE → SAMPLE when `enable`=1. On entry, clear the divider counter and the sample counter.
- SAMPLE:
  - The divider counts 0..CLK_DIV-1. `adc_sample_req` pulses when the count is 0, so the first request is issued on the first SAMPLE clock.
  - A sample is accepted when `ast_sink_valid`=1 and `ast_sink_error`=0.
  - When `ast_sink_valid`=1 and `ast_sink_error`≠0, the sample is not counted and `err_count` increments, saturating at 255.
  - The transition to CLOSE occurs on the clock that accepts sample number SAMPLES_PER_CYCLE.
  - No request is issued on or after that clock.
- CLOSE: lasts 1 clock with `end_cycle`=1, then → WAIT_RESULT.
- WAIT_RESULT:
  - `end_cycle` stays 1 and the timeout counter runs.
  - On `source_valid`=1, latch `source_data` into `result_data`, set `result_valid`, and go → HOLD.
  - If the timeout counter reaches RESULT_TIMEOUT first, set `timeout` and go → IDLE; `result_valid` is not asserted.
- HOLD:
  - `end_cycle`=0.
  - When `result_valid`=1 and `result_ready`=1 in the same clock, clear `result_valid`. Then go → SAMPLE if `enable`=1, else → IDLE.
  - `result_data` is stable while `result_valid`=1.
- `ast_sink_valid` outside SAMPLE is ignored and does not affect `err_count`.
- `source_valid` outside WAIT_RESULT is ignored.
- `enable` is sampled only in IDLE and at the HOLD exit. Deasserting it mid-window does not abort the window.
- `source_valid` and timeout expiry in the same clock: the result wins and `timeout` is not set.
- `reset_n` low at any time forces IDLE immediately. Reset values:
  - `adc_sample_req`=0, `end_cycle`=0, `result_valid`=0, `busy`=0, `timeout`=0.
  - `result_data`=16'h0000, `err_count`=8'h00.

## Timing
- All outputs are registered and Moore-decoded from state and counters; there is no combinational path from input to output.
- Request spacing is exactly CLK_DIV clocks. The first request comes 1 clock after `enable` is sampled high in IDLE.
- `end_cycle` rises 1 clock after the final sample is accepted. It is held until the clock after `source_valid` is accepted, so the analysis block sees exactly one rising edge per window.
- `result_valid` rises 1 clock after `source_valid`.
- With `result_ready` tied high and `enable`=1, each window closes in HOLD for 1 clock, and the next SAMPLE entry issues its request immediately.
- Counter widths are `$clog2(param+1)`. The counters do not wrap; each is cleared on state entry.

## Structure
- Shared package `sample_ctrl_pkg` contains:
  - the state enum (`SC_IDLE`, `SC_SAMPLE`, `SC_CLOSE`, `SC_WAIT`, `SC_HOLD`);
  - `ERR_CNT_W`=8;
  - `RESULT_W`=16.
- One sub-module, `sample_strobe_gen`: a CLK_DIV divider with synchronous clear and enable, emitting the request pulse.
- The FSM, counters and result register live in the top.

## Test plan
- Reset and idle: `reset_n` low then high, `enable`=0 for 100 clocks → all outputs hold their reset values and there are no requests.
- Nominal window: CLK_DIV=4, SAMPLES=8, the ADC returns valid 2 clocks after each request, analysis returns 16'hBEEF 5 clocks after the `end_cycle` rise → 8 requests spaced 4 clocks, one `end_cycle` rise, `result_data`=16'hBEEF with `result_valid` held until `result_ready`.
- Error samples: 3 of 11 samples carry `ast_sink_error`=2'b01 → the window still closes after 8 good samples and `err_count`=3. A separate run forces 300 errors → `err_count`=255.
- Timeout: `source_valid` is never sent with RESULT_TIMEOUT=16 → `timeout`=1 after 16 WAIT clocks, state returns to IDLE, `result_valid`=0, `end_cycle`=0.
- Backpressure and back-to-back: `result_ready` low for 10 clocks, then high, with `enable`=1 → `result_data` is stable throughout and the next request follows the handshake clock by 1 clock.
- Reset mid-WAIT: `reset_n` pulsed low while `end_cycle`=1 → `end_cycle` drops asynchronously and the FSM is in IDLE.
